// File: rtl/adc_multi_ch_model.sv
// Behavioural multi-channel SPI ADC: a 16-bit command frame selects a channel, and a
// later frame shifts out that channel's held sample, MSB first, in SPI mode 0.
module adc_multi_ch_model #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DATA_W     = 12,
  parameter logic [7:0]  VALID_MASK = 8'b0011_0001,
  parameter bit          PAIRED     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     bad_ch,
  output logic [15:0]              frame_cnt
);

  typedef enum logic {StIdle, StXfer} state_e;

  localparam logic PhCmd  = 1'b0;
  localparam logic PhRead = 1'b1;

  state_e      state_q;
  logic        phase_q;
  logic [2:0]  ptr_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] tx_q;
  logic [15:0] rx_q;
  logic [2:0]  ss_sr_q;
  logic [2:0]  sclk_sr_q;
  logic [2:0]  mosi_sr_q;

  logic              ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_sync;
  logic [DATA_W-1:0] sel_data;
  logic [15:0]       tx_load;
  logic [2:0]        new_ptr;
  logic              unused_bits;

  // Index [1] is the synchronized sample, [2] the history sample.
  assign ss_fall   =  ss_sr_q[2]   & ~ss_sr_q[1];
  assign ss_rise   = ~ss_sr_q[2]   &  ss_sr_q[1];
  assign sclk_rise = ~sclk_sr_q[2] &  sclk_sr_q[1];
  assign sclk_fall =  sclk_sr_q[2] & ~sclk_sr_q[1];
  assign mosi_sync =  mosi_sr_q[1];
  assign new_ptr   =  rx_q[13:11];
  assign MISO      =  tx_q[15];
  assign unused_bits = rx_q[15] ^ mosi_sr_q[2];

  function automatic logic ch_legal(input logic [2:0] p);
    return (32'(p) < NUM_CH) && VALID_MASK[p];
  endfunction

  // Illegal pointers read back as zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ptr_q == 3'(i) && VALID_MASK[i]) sel_data = ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    tx_load = '0;
    tx_load[DATA_W-1:0] = sel_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= PhCmd;
      ptr_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      bad_ch     <= 1'b0;
      ss_sr_q    <= 3'b111;
      sclk_sr_q  <= 3'b000;
      mosi_sr_q  <= 3'b000;
    end else begin
      ss_sr_q    <= {ss_sr_q[1:0], SS_n};
      sclk_sr_q  <= {sclk_sr_q[1:0], SCLK};
      mosi_sr_q  <= {mosi_sr_q[1:0], MOSI};
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      bad_ch     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q   <= StXfer;
            bit_cnt_q <= '0;
            tx_q      <= tx_load;
          end
        end
        StXfer: begin
          // Slave deselect wins over any SCLK edge seen in the same cycle.
          if (ss_rise) begin
            state_q <= StIdle;
            if (bit_cnt_q == 5'd16) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
              if (!PAIRED || phase_q == PhCmd) begin
                ptr_q  <= new_ptr;
                bad_ch <= ~ch_legal(new_ptr);
                if (PAIRED) phase_q <= PhRead;
              end else begin
                phase_q <= PhCmd;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_q <= {rx_q[14:0], mosi_sync};
              if (bit_cnt_q != 5'd17) bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            if (sclk_fall && bit_cnt_q != 5'd0) tx_q <= {tx_q[14:0], 1'b0};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_multi_ch_model.sv
// Directed bench: DUT a uses default parameters (paired frames), DUT b runs unpaired with
// six 10-bit channels. Both share SCLK/MOSI and have separate slave selects.
module tb_adc_multi_ch_model;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ss_n_a = 1'b1;
  logic        ss_n_b = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso_a, miso_b;
  logic [95:0] ch_data_a = '0;
  logic [59:0] ch_data_b = '0;
  logic        frame_done_a, frame_err_a, bad_ch_a;
  logic        frame_done_b, frame_err_b, bad_ch_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done [2] = '{0, 0};
  int n_err  [2] = '{0, 0};
  int n_bad  [2] = '{0, 0};
  int n_bdn  [2] = '{0, 0};

  always #5 clk = ~clk;

  adc_multi_ch_model dut_a (
    .clk(clk), .rst(rst), .SS_n(ss_n_a), .SCLK(sclk), .MOSI(mosi), .MISO(miso_a),
    .ch_data(ch_data_a), .frame_done(frame_done_a), .frame_err(frame_err_a),
    .bad_ch(bad_ch_a), .frame_cnt(frame_cnt_a)
  );

  adc_multi_ch_model #(.NUM_CH(6), .DATA_W(10), .PAIRED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .SS_n(ss_n_b), .SCLK(sclk), .MOSI(mosi), .MISO(miso_b),
    .ch_data(ch_data_b), .frame_done(frame_done_b), .frame_err(frame_err_b),
    .bad_ch(bad_ch_b), .frame_cnt(frame_cnt_b)
  );

  always @(posedge clk) begin
    if (frame_done_a) n_done[0] <= n_done[0] + 1;
    if (frame_err_a)  n_err[0]  <= n_err[0] + 1;
    if (bad_ch_a)     n_bad[0]  <= n_bad[0] + 1;
    if (bad_ch_a && frame_done_a) n_bdn[0] <= n_bdn[0] + 1;
    if (frame_done_b) n_done[1] <= n_done[1] + 1;
    if (frame_err_b)  n_err[1]  <= n_err[1] + 1;
    if (bad_ch_b)     n_bad[1]  <= n_bad[1] + 1;
    if (bad_ch_b && frame_done_b) n_bdn[1] <= n_bdn[1] + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ss_n_a = 1'b1;
    ss_n_b = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    rst    = 1'b1;
    tick(3);
    rst    = 1'b0;
    tick(4);
  endtask

  // Master side of one frame; MISO is captured at each SCLK rise.
  task automatic spi_xfer(input bit sel_b, input logic [15:0] cmd, input int nbits,
                          input int chg_at, input int rst_at, output logic [15:0] rx);
    rx = '0;
    if (sel_b) ss_n_b = 1'b0; else ss_n_a = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? cmd[15-i] : 1'b0;
      tick(8);
      sclk = 1'b1;
      rx = {rx[14:0], (sel_b ? miso_b : miso_a)};
      tick(8);
      sclk = 1'b0;
      if (i == chg_at) ch_data_a[11:0] = 12'h123;
      if (i == rst_at) begin
        ss_n_a = 1'b1;
        rst    = 1'b1;
        tick(2);
        rst    = 1'b0;
        tick(6);
        return;
      end
    end
    tick(8);
    ss_n_a = 1'b1;
    ss_n_b = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (miso_a !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", miso_a); end
    n_checks++;
    if (frame_cnt_a !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnt got %h want 0000", frame_cnt_a);
    end
    n_checks++;
    if ({frame_done_a, frame_err_a, bad_ch_a} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got %b want 000", {frame_done_a, frame_err_a, bad_ch_a});
    end
  endtask

  task automatic test_basic();
    logic [15:0] rx;
    int d0;
    do_reset();
    d0 = n_done[0];
    spi_xfer(1'b0, 16'h0000, 16, -1, -1, rx);
    n_checks++;
    if (rx !== 16'h0C00) begin n_fail++; $display("FAIL basic_data got %h want 0c00", rx); end
    n_checks++;
    if (n_done[0] - d0 !== 1) begin
      n_fail++; $display("FAIL basic_done got %0d want 1", n_done[0] - d0);
    end
    n_checks++;
    if (frame_cnt_a !== 16'd1) begin
      n_fail++; $display("FAIL basic_cnt got %0d want 1", frame_cnt_a);
    end
  endtask

  task automatic test_paired();
    logic [15:0] rx;
    logic [15:0] want [4] = '{16'h0C00, 16'h05A5, 16'h05A5, 16'h0C00};
    logic [15:0] cmds [4] = '{16'h2000, 16'hFFFF, 16'h0000, 16'h0000};
    int b0;
    do_reset();
    b0 = n_bad[0];
    for (int f = 0; f < 4; f++) begin
      spi_xfer(1'b0, cmds[f], 16, -1, -1, rx);
      n_checks++;
      if (rx !== want[f]) begin
        n_fail++; $display("FAIL paired_frame%0d got %h want %h", f, rx, want[f]);
      end
    end
    n_checks++;
    if (frame_cnt_a !== 16'd4) begin
      n_fail++; $display("FAIL paired_cnt got %0d want 4", frame_cnt_a);
    end
    n_checks++;
    if (n_bad[0] - b0 !== 0) begin
      n_fail++; $display("FAIL paired_nobad got %0d want 0", n_bad[0] - b0);
    end
  endtask

  task automatic test_bad_ch();
    logic [15:0] rx;
    int b0, bd0;
    do_reset();
    b0  = n_bad[0];
    bd0 = n_bdn[0];
    spi_xfer(1'b0, 16'h1000, 16, -1, -1, rx);
    n_checks++;
    if (n_bdn[0] - bd0 !== 1 || n_bad[0] - b0 !== 1) begin
      n_fail++; $display("FAIL badch_pulse got %0d/%0d want 1/1", n_bad[0] - b0, n_bdn[0] - bd0);
    end
    spi_xfer(1'b0, 16'h0000, 16, -1, -1, rx);
    n_checks++;
    if (rx !== 16'h0000) begin n_fail++; $display("FAIL badch_data got %h want 0000", rx); end
  endtask

  task automatic test_short_frame();
    logic [15:0] rx;
    int d0, e0;
    do_reset();
    spi_xfer(1'b0, 16'h2000, 16, -1, -1, rx);
    d0 = n_done[0];
    e0 = n_err[0];
    spi_xfer(1'b0, 16'h0000, 9, -1, -1, rx);
    n_checks++;
    if (n_err[0] - e0 !== 1 || n_done[0] - d0 !== 0) begin
      n_fail++; $display("FAIL short9 err/done got %0d/%0d want 1/0", n_err[0] - e0, n_done[0] - d0);
    end
    n_checks++;
    if (frame_cnt_a !== 16'd1) begin
      n_fail++; $display("FAIL short9_cnt got %0d want 1", frame_cnt_a);
    end
    spi_xfer(1'b0, 16'h0000, 16, -1, -1, rx);
    n_checks++;
    if (rx !== 16'h05A5) begin n_fail++; $display("FAIL short_ptr got %h want 05a5", rx); end
    e0 = n_err[0];
    spi_xfer(1'b0, 16'h0000, 17, -1, -1, rx);
    n_checks++;
    if (n_err[0] - e0 !== 1 || frame_cnt_a !== 16'd2) begin
      n_fail++; $display("FAIL long17 err/cnt got %0d/%0d want 1/2", n_err[0] - e0, frame_cnt_a);
    end
  endtask

  task automatic test_hold_and_rst();
    logic [15:0] rx;
    int d0, e0;
    do_reset();
    spi_xfer(1'b0, 16'h0000, 16, 3, -1, rx);
    n_checks++;
    if (rx !== 16'h0C00) begin n_fail++; $display("FAIL hold_data got %h want 0c00", rx); end
    spi_xfer(1'b0, 16'h0000, 16, -1, -1, rx);
    n_checks++;
    if (rx !== 16'h0123) begin n_fail++; $display("FAIL hold_next got %h want 0123", rx); end
    d0 = n_done[0];
    e0 = n_err[0];
    spi_xfer(1'b0, 16'h0000, 16, -1, 5, rx);
    tick(20);
    n_checks++;
    if ({miso_a, frame_done_a, frame_err_a, bad_ch_a} !== 4'b0000 || frame_cnt_a !== 16'h0) begin
      n_fail++; $display("FAIL midrst_outputs got %b cnt %h want 0000 cnt 0000",
                         {miso_a, frame_done_a, frame_err_a, bad_ch_a}, frame_cnt_a);
    end
    n_checks++;
    if (n_done[0] - d0 !== 0 || n_err[0] - e0 !== 0) begin
      n_fail++; $display("FAIL midrst_pulses got %0d/%0d want 0/0", n_done[0] - d0, n_err[0] - e0);
    end
  endtask

  task automatic test_unpaired();
    logic [15:0] rx;
    logic [15:0] cmds [6] = '{16'h2800, 16'h0000, 16'h2800, 16'h3000, 16'h0000, 16'h0000};
    logic [15:0] want [6] = '{16'h0155, 16'h02CA, 16'h0155, 16'h02CA, 16'h0000, 16'h0155};
    int b0;
    do_reset();
    b0 = n_bdn[1];
    for (int f = 0; f < 6; f++) begin
      spi_xfer(1'b1, cmds[f], 16, -1, -1, rx);
      n_checks++;
      if (rx !== want[f]) begin
        n_fail++; $display("FAIL unpaired_frame%0d got %h want %h", f, rx, want[f]);
      end
    end
    n_checks++;
    if (n_bdn[1] - b0 !== 1) begin
      n_fail++; $display("FAIL unpaired_badch got %0d want 1", n_bdn[1] - b0);
    end
    n_checks++;
    if (frame_cnt_b !== 16'd6) begin
      n_fail++; $display("FAIL unpaired_cnt got %0d want 6", frame_cnt_b);
    end
  endtask

  initial begin
    ch_data_a[0 +: 12]  = 12'hC00;
    ch_data_a[48 +: 12] = 12'h5A5;
    ch_data_a[24 +: 12] = 12'h777;
    ch_data_b[0 +: 10]  = 10'h155;
    ch_data_b[50 +: 10] = 10'h2CA;
    test_reset();
    test_basic();
    test_paired();
    test_bad_ch();
    test_short_frame();
    test_hold_and_rst();
    test_unpaired();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
